// File: rtl/wavetable_voice_scheduler.sv
// Frame sequencer sharing one wavetable ROM bank across NUMVOICES voices; sums one mix word per I2S request.
// Optional build macro VOICE_SKIP_EN: inactive voices take a single ISSUE cycle instead of a full ROM slot.
module wavetable_voice_scheduler #(
  parameter int NUMVOICES = 10,
  parameter int VOICE_AW  = 4,
  parameter int ROM_LAT   = 2,
  parameter int DW        = 16,
  parameter int ACCW      = 20
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 samp_req,
  input  logic                 gen_en,
  input  logic [NUMVOICES-1:0] voice_active,
  input  logic [DW-1:0]        rom_data,
  input  logic                 clr_overrun,
  output logic                 rom_en,
  output logic [VOICE_AW-1:0]  rom_voice,
  output logic [NUMVOICES-1:0] phasor_step,
  output logic [ACCW-1:0]      mix_out,
  output logic                 mix_valid,
  output logic                 busy,
  output logic                 overrun
);

`ifdef VOICE_SKIP_EN
  localparam bit SKIP_INACTIVE = 1'b1;
`else
  localparam bit SKIP_INACTIVE = 1'b0;
`endif
  localparam int CW = (ROM_LAT > 2) ? $clog2(ROM_LAT - 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [VOICE_AW-1:0]  v_q, v_d;
  logic [ACCW-1:0]      acc_q, acc_d;
  logic                 active_q, active_d;
  logic [CW-1:0]        wcnt_q, wcnt_d;
  logic                 rom_en_q, rom_en_d;
  logic [VOICE_AW-1:0]  rom_voice_q, rom_voice_d;
  logic [NUMVOICES-1:0] phasor_q, phasor_d;
  logic [ACCW-1:0]      mix_out_q, mix_out_d;
  logic                 mix_valid_q, mix_valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic                 issue_go, cap_go, done_go;
  logic [VOICE_AW-1:0]  issue_v;
  logic [ACCW-1:0]      done_val, contrib, capture_sum;
  logic [NUMVOICES-1:0] v_onehot;
  logic                 last_voice;

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    acc_d       = acc_q;
    active_d    = active_q;
    wcnt_d      = wcnt_q;
    rom_en_d    = 1'b0;
    rom_voice_d = rom_voice_q;
    phasor_d    = '0;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    issue_go    = 1'b0;
    issue_v     = '0;
    cap_go      = 1'b0;
    done_go     = 1'b0;
    done_val    = acc_q;

    contrib     = active_q ? {{(ACCW-DW){rom_data[DW-1]}}, rom_data} : '0;
    capture_sum = acc_q + contrib;
    v_onehot    = {{(NUMVOICES-1){1'b0}}, 1'b1} << v_q;
    last_voice  = (v_q == VOICE_AW'(NUMVOICES - 1));

    case (state_q)
      S_IDLE: begin
        if (samp_req && gen_en) begin
          issue_go = 1'b1;
          acc_d    = '0;
        end
      end
      S_ISSUE: begin
        if (SKIP_INACTIVE && !active_q) begin
          if (last_voice) done_go = 1'b1;
          else begin
            issue_go = 1'b1;
            issue_v  = v_q + VOICE_AW'(1);
          end
        end else if (ROM_LAT == 1) begin
          cap_go = 1'b1;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = CW'(ROM_LAT - 2);
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) cap_go = 1'b1;
        else              wcnt_d = wcnt_q - CW'(1);
      end
      S_CAPTURE: begin
        acc_d = capture_sum;
        if (last_voice) begin
          done_go  = 1'b1;
          done_val = capture_sum;
        end else begin
          issue_go = 1'b1;
          issue_v  = v_q + VOICE_AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The mask bit is taken on the edge that enters ISSUE so rom_en can be a registered output in that cycle.
    if (issue_go) begin
      state_d     = S_ISSUE;
      v_d         = issue_v;
      rom_voice_d = issue_v;
      active_d    = voice_active[issue_v];
      rom_en_d    = voice_active[issue_v];
    end
    if (cap_go) begin
      state_d  = S_CAPTURE;
      phasor_d = active_q ? v_onehot : '0;
    end
    if (done_go) begin
      state_d     = S_DONE;
      mix_out_d   = done_val;
      mix_valid_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
    if (samp_req && state_q != S_IDLE) overrun_d = 1'b1;
    else if (clr_overrun)              overrun_d = 1'b0;
    else                               overrun_d = overrun_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      v_q         <= '0;
      acc_q       <= '0;
      active_q    <= 1'b0;
      wcnt_q      <= '0;
      rom_en_q    <= 1'b0;
      rom_voice_q <= '0;
      phasor_q    <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      active_q    <= active_d;
      wcnt_q      <= wcnt_d;
      rom_en_q    <= rom_en_d;
      rom_voice_q <= rom_voice_d;
      phasor_q    <= phasor_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rom_en      = rom_en_q;
  assign rom_voice   = rom_voice_q;
  assign phasor_step = phasor_q;
  assign mix_out     = mix_out_q;
  assign mix_valid   = mix_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Randomized frame bench for wavetable_voice_scheduler: a schedule/sum model predicts every output cycle by cycle.
module tb_wavetable_voice_scheduler;
  localparam int NV = 10;
  localparam int AW = 4;
  localparam int L  = 2;
  localparam int DW = 16;
  localparam int ACCW = 20;
`ifdef VOICE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Reset, samp_req, gen_en, clr_overrun;
  logic [NV-1:0]   voice_active;
  logic [DW-1:0]   rom_data;
  logic            rom_en, mix_valid, busy, overrun;
  logic [AW-1:0]   rom_voice;
  logic [NV-1:0]   phasor_step;
  logic [ACCW-1:0] mix_out;

  wavetable_voice_scheduler #(.NUMVOICES(NV), .VOICE_AW(AW), .ROM_LAT(L), .DW(DW), .ACCW(ACCW)) dut (
    .Clk(Clk), .Reset(Reset), .samp_req(samp_req), .gen_en(gen_en), .voice_active(voice_active),
    .rom_data(rom_data), .clr_overrun(clr_overrun), .rom_en(rom_en), .rom_voice(rom_voice),
    .phasor_step(phasor_step), .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun));

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // ROM bank model: returns the table word L cycles after rom_en, garbage otherwise.
  logic [DW-1:0] rom_tbl [16];
  logic          pipe_en [L];
  logic [AW-1:0] pipe_v  [L];
  logic [DW-1:0] junk_q;
  always @(posedge Clk) begin
    junk_q <= DW'($urandom);
    if (Reset) begin
      for (int i = 0; i < L; i++) pipe_en[i] <= 1'b0;
    end else begin
      pipe_en[0] <= rom_en;
      pipe_v[0]  <= rom_voice;
      for (int i = 1; i < L; i++) begin
        pipe_en[i] <= pipe_en[i-1];
        pipe_v[i]  <= pipe_v[i-1];
      end
    end
  end
  always_comb rom_data = pipe_en[L-1] ? rom_tbl[pipe_v[L-1]] : junk_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int              exp_issue [NV];
  int              exp_cap   [NV];
  int              exp_done;
  logic [ACCW-1:0] exp_mix;
  logic [ACCW-1:0] mix_m = '0;
  logic            ovr_m = 1'b0;

  function automatic void plan(input logic [NV-1:0] mask);
    int t = 1;
    int s = 0;
    for (int v = 0; v < NV; v++) begin
      exp_issue[v] = t;
      exp_cap[v]   = mask[v] ? t + L : -1;
      t += (mask[v] || !SKIP) ? L + 1 : 1;
      if (mask[v]) s += int'($signed(rom_tbl[v]));
    end
    exp_done = t;
    exp_mix  = ACCW'(s);
  endfunction

  // One frame starting with samp_req in relative cycle 0; optional extra request, clear and gen_en drop cycles.
  task automatic run_frame(input logic [NV-1:0] mask, input int req2, input int clr, input int gdrop);
    int ncyc;
    logic exp_en, busy_e;
    logic [NV-1:0] exp_ph;
    plan(mask);
    ncyc = (exp_done + 3 > clr + 2) ? exp_done + 3 : clr + 2;
    voice_active = mask;
    gen_en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      samp_req    = (c == 0) || (c == req2);
      clr_overrun = (c == clr);
      if (c == gdrop) gen_en = 1'b0;
      @(negedge Clk);
      exp_en = 1'b0;
      exp_ph = '0;
      busy_e = (c >= 1) && (c <= exp_done);
      for (int v = 0; v < NV; v++) begin
        if (mask[v] && exp_issue[v] == c) exp_en = 1'b1;
        if (exp_cap[v] == c) exp_ph[v] = 1'b1;
        if (exp_issue[v] == c) check($sformatf("c%0d rom_voice", c), 32'(rom_voice), 32'(v));
      end
      check($sformatf("c%0d rom_en", c), 32'(rom_en), 32'(exp_en));
      check($sformatf("c%0d phasor_step", c), 32'(phasor_step), 32'(exp_ph));
      check($sformatf("c%0d mix_valid", c), 32'(mix_valid), 32'(c == exp_done));
      check($sformatf("c%0d busy", c), 32'(busy), 32'(busy_e));
      check($sformatf("c%0d overrun", c), 32'(overrun), 32'(ovr_m));
      if (c == exp_done) mix_m = exp_mix;
      check($sformatf("c%0d mix_out", c), 32'(mix_out), 32'(mix_m));
      if (samp_req && busy_e) ovr_m = 1'b1;
      else if (clr_overrun)   ovr_m = 1'b0;
      @(posedge Clk); #1;
    end
    samp_req = 1'b0; clr_overrun = 1'b0; gen_en = 1'b1;
    $display("frame mask=%b done@%0d mix=%0d overrun=%0b", mask, exp_done, $signed(mix_out), overrun);
  endtask

  task automatic fill_tbl(input int val);
    for (int v = 0; v < 16; v++) rom_tbl[v] = DW'(val);
  endtask

  initial begin
    Reset = 1'b1; samp_req = 1'b0; gen_en = 1'b0; clr_overrun = 1'b0; voice_active = '0;
    fill_tbl(0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst rom_en", 32'(rom_en), 32'd0);
    check("rst rom_voice", 32'(rom_voice), 32'd0);
    check("rst phasor", 32'(phasor_step), 32'd0);
    check("rst mix_out", 32'(mix_out), 32'd0);
    check("rst mix_valid", 32'(mix_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    fill_tbl(100);
    run_frame('1, -1, -1, -1);
    check("t1 mix 1000", 32'(mix_out), 32'(ACCW'(1000)));

    fill_tbl(-32768);
    run_frame('1, -1, -1, -1);
    check("t2 mix -327680", 32'(mix_out), 32'h000B0000);

    fill_tbl(7);
    run_frame(10'b0000000101, -1, -1, -1);
    check("t3 mix 14", 32'(mix_out), 32'd14);

    for (int k = 0; k < NV; k++) rom_tbl[k] = DW'($urandom);
    run_frame('1, 10, 40, -1);
    run_frame('1, 12, 12, 5);
    check("prio overrun kept", 32'(overrun), 32'd1);
    run_frame(NV'($urandom), -1, 3, -1);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NV; k++) rom_tbl[k] = DW'($urandom);
      run_frame(NV'($urandom), -1, -1, (r % 2 == 0) ? int'($urandom_range(1, 20)) : -1);
    end

    // Reset mid-frame at relative cycle 12
    voice_active = '1; gen_en = 1'b1; samp_req = 1'b1;
    @(posedge Clk); #1;
    samp_req = 1'b0;
    repeat (11) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int c = 13; c < 20; c++) begin
      @(negedge Clk);
      check($sformatf("rstmid c%0d outputs", c),
            {5'd0, rom_en, rom_voice, phasor_step, mix_valid, busy, overrun, 9'd0}, 32'd0);
      check($sformatf("rstmid c%0d mix_out", c), 32'(mix_out), 32'd0);
      @(posedge Clk); #1;
    end
    ovr_m = 1'b0; mix_m = '0;
    run_frame('1, -1, -1, -1);

    // Requests with generation disabled are ignored entirely
    gen_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      samp_req = (c == 0) || (c == 7);
      @(negedge Clk);
      check($sformatf("gen0 c%0d rom_en", c), 32'(rom_en), 32'd0);
      check($sformatf("gen0 c%0d busy", c), 32'(busy), 32'd0);
      check($sformatf("gen0 c%0d overrun", c), 32'(overrun), 32'(ovr_m));
      check($sformatf("gen0 c%0d mix_valid", c), 32'(mix_valid), 32'd0);
      @(posedge Clk); #1;
    end
    samp_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
